// File: rtl/div_operand_front.sv
// div_operand_front
//   Issue stage for the 32-bit add/subtract-alternating sign-magnitude divider.
//   Accepts a dividend/divisor pair over valid/ready and converts both to 33-bit
//   sign-magnitude words (bit 32 always 0). The signs travel on separate sideband
//   outputs. The words are held stable for the divider's LATENCY-cycle pipeline,
//   and a one-cycle capture strobe is raised when the divider result is valid.
//
// Parameters
//   LATENCY  cycles from operand launch to divider result valid (>= 2)
//   CNT_W    hold counter width (2**CNT_W > LATENCY)
//
// Configuration macro
//   DIV_FRONT_DBZ_BYPASS_EN  divide-by-zero ops skip the hold count and strobe
//                            on the cycle after accept
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   in_valid / in_ready        operand handshake; ready only while idle
//   in_signed                  1: two's complement operands, 0: unsigned
//   in_dividend, in_divisor    32-bit operands
//   div_dividend, div_divisor  33-bit magnitudes to the divider
//   busy                       operation in flight
//   cap_strobe                 1-cycle pulse: divider outputs valid
//   q_neg, r_neg               quotient / remainder sign sidebands
//   dbz                        divisor was zero for the current op
module div_operand_front #(
  parameter int LATENCY = 100,
  parameter int CNT_W   = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_signed,
  input  logic [31:0] in_dividend,
  input  logic [31:0] in_divisor,
  output logic [32:0] div_dividend,
  output logic [32:0] div_divisor,
  output logic        busy,
  output logic        cap_strobe,
  output logic        q_neg,
  output logic        r_neg,
  output logic        dbz
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;

  logic        accept;
  logic        a_neg, b_neg, b_zero;
  logic [31:0] a_mag, b_mag;

  assign accept = in_valid && (state == IDLE);

  // Two's-complement negate maps 0x8000_0000 onto itself, which is exactly the
  // required magnitude for -2^31.
  assign a_neg  = in_signed && in_dividend[31];
  assign b_neg  = in_signed && in_divisor[31];
  assign a_mag  = a_neg ? (~in_dividend + 32'd1) : in_dividend;
  assign b_mag  = b_neg ? (~in_divisor + 32'd1) : in_divisor;
  assign b_zero = (in_divisor == '0);

  // Operand and sideband registers: written only on the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_dividend <= '0;
      div_divisor  <= '0;
      q_neg        <= 1'b0;
      r_neg        <= 1'b0;
      dbz          <= 1'b0;
    end else if (accept) begin
      div_dividend <= {1'b0, a_mag};
      div_divisor  <= {1'b0, b_mag};
      q_neg        <= b_zero ? 1'b0 : (a_neg ^ b_neg);
      r_neg        <= b_zero ? 1'b0 : a_neg;
      dbz          <= b_zero;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // The counter is loaded with LATENCY-1 and leaves HOLD as it reaches zero, so
  // the first HOLD cycle is cycle 1 after launch and DONE lands on cycle LATENCY.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (in_valid) begin
`ifdef DIV_FRONT_DBZ_BYPASS_EN
          if (b_zero) begin
            state_nx = DONE;
            cnt_nx   = '0;
          end else begin
            state_nx = HOLD;
            cnt_nx   = CNT_W'(LATENCY - 1);
          end
`else
          state_nx = HOLD;
          cnt_nx   = CNT_W'(LATENCY - 1);
`endif
        end
      end
      HOLD: begin
        cnt_nx = cnt - 1'b1;
        if (cnt <= CNT_W'(1)) begin
          state_nx = DONE;
          cnt_nx   = '0;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  assign in_ready   = (state == IDLE);
  assign busy       = (state == HOLD) || (state == DONE);
  assign cap_strobe = (state == DONE);

endmodule

// File: tb/tb_div_operand_front.sv
module tb_div_operand_front;

  localparam int LATENCY = 100;
  localparam int CNT_W   = 7;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_signed;
  logic [31:0] in_dividend;
  logic [31:0] in_divisor;
  logic [32:0] div_dividend;
  logic [32:0] div_divisor;
  logic        busy;
  logic        cap_strobe;
  logic        q_neg;
  logic        r_neg;
  logic        dbz;

  div_operand_front #(.LATENCY(LATENCY), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_signed    (in_signed),
    .in_dividend  (in_dividend),
    .in_divisor   (in_divisor),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .busy         (busy),
    .cap_strobe   (cap_strobe),
    .q_neg        (q_neg),
    .r_neg        (r_neg),
    .dbz          (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [32:0] a;
    logic [32:0] b;
    logic        qn;
    logic        rn;
    logic        dz;
    int unsigned done_cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc;
  int unsigned next_free;
  int unsigned acc_cnt;
  int          n_tests;
  int          n_fail;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mag(input logic s, input logic [31:0] x);
    if (s && x[31]) return 32'd0 - x;
    return x;
  endfunction

  // Single process owns the scoreboard: accept modelling at the rising edge,
  // output checking at the falling edge.
  initial begin
    cyc       = 0;
    next_free = 0;
    acc_cnt   = 0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        sb.delete();
        next_free = 0;
      end else if (in_valid && cyc >= next_free) begin
        exp_t e;
        logic sa, sbn;
        sa    = in_signed && in_dividend[31];
        sbn   = in_signed && in_divisor[31];
        e.a   = {1'b0, mag(in_signed, in_dividend)};
        e.b   = {1'b0, mag(in_signed, in_divisor)};
        e.dz  = (in_divisor == 32'd0);
        e.qn  = e.dz ? 1'b0 : (sa ^ sbn);
        e.rn  = e.dz ? 1'b0 : sa;
`ifdef DIV_FRONT_DBZ_BYPASS_EN
        e.done_cyc = e.dz ? cyc + 1 : cyc + LATENCY;
`else
        e.done_cyc = cyc + LATENCY;
`endif
        next_free = e.done_cyc + 1;
        sb.push_back(e);
        acc_cnt++;
      end
      cyc++;
      @(negedge clk);
      if (rst_n) begin
        logic exp_ready, exp_strobe;
        exp_ready  = (cyc >= next_free);
        exp_strobe = (sb.size() > 0) && (sb[0].done_cyc == cyc);
        check("in_ready", {63'd0, in_ready}, {63'd0, exp_ready});
        check("busy", {63'd0, busy}, {63'd0, !exp_ready});
        check("cap_strobe", {63'd0, cap_strobe}, {63'd0, exp_strobe});
        if (sb.size() > 0) begin
          check("div_dividend", {31'd0, div_dividend}, {31'd0, sb[0].a});
          check("div_divisor", {31'd0, div_divisor}, {31'd0, sb[0].b});
          check("q_neg", {63'd0, q_neg}, {63'd0, sb[0].qn});
          check("r_neg", {63'd0, r_neg}, {63'd0, sb[0].rn});
          check("dbz", {63'd0, dbz}, {63'd0, sb[0].dz});
        end
        if (exp_strobe) void'(sb.pop_front());
      end
    end
  end

  // Present an operand pair and hold in_valid until the model records the accept.
  task automatic op(input logic s, input logic [31:0] a, input logic [31:0] b, input bit keep);
    int unsigned start;
    start       = acc_cnt;
    in_signed   = s;
    in_dividend = a;
    in_divisor  = b;
    in_valid    = 1'b1;
    for (int i = 0; i < 400 && acc_cnt == start; i++) begin
      @(posedge clk);
      #2;
    end
    check("accept_timeout", {63'd0, acc_cnt != start}, 64'd1);
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 400 && sb.size() > 0; i++) begin
      @(posedge clk);
      #2;
    end
    check("drain_timeout", {63'd0, sb.size() == 0}, 64'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, {63'd0, in_ready}, 64'd1);
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_strobe"}, {63'd0, cap_strobe}, 64'd0);
    check({tag, "_dd"}, {31'd0, div_dividend}, 64'd0);
    check({tag, "_dv"}, {31'd0, div_divisor}, 64'd0);
    check({tag, "_side"}, {61'd0, q_neg, r_neg, dbz}, 64'd0);
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_signed   = 1'b0;
    in_dividend = '0;
    in_divisor  = '0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check_reset_values("reset");

    // Idle with in_valid low: the monitor flags any stray strobe.
    repeat (20) @(posedge clk);
    #2;

    op(1'b1, 32'hFFFF_FF9C, 32'd7, 1'b0);           // -100 / 7
    drain();
    op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);   // -2^31 / -1
    drain();

    // Unsigned op with in_valid held through HOLD; the second op must wait.
    op(1'b0, 32'hFFFF_FFFF, 32'd3, 1'b1);
    op(1'b1, 32'd50, 32'hFFFF_FFF6, 1'b0);          // 50 / -10
    drain();

    op(1'b1, 32'hFFFF_FFF0, 32'd0, 1'b0);           // divide by zero, signed
    drain();
    op(1'b0, 32'd12345, 32'd0, 1'b0);               // divide by zero, unsigned
    drain();

    // Inputs changed after accept must not disturb the held words.
    op(1'b1, 32'd9, 32'd4, 1'b0);
    in_valid    = 1'b0;
    in_dividend = 32'hDEAD_BEEF;
    in_divisor  = 32'h1234_5678;
    in_signed   = 1'b0;
    drain();

    for (int k = 0; k < 4; k++) begin
      op(1'($urandom_range(0, 1)), $urandom, $urandom, 1'b0);
      drain();
    end

    // Reset pulse mid-HOLD aborts the op without a strobe.
    op(1'b1, 32'hFFFF_FF00, 32'd5, 1'b0);
    repeat (30) @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check_reset_values("abort");
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check_reset_values("post_abort");
    op(1'b1, 32'd1000, 32'hFFFF_FFFD, 1'b0);        // 1000 / -3
    drain();

    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
